// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC and the IF/ID register and drives a req/ack instruction-memory
// port. Applies hazard-unit stalls, redirects and squashes, including
// redirects that arrive while a fetch is still outstanding.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the FetchCnt/SquashCnt
// performance counters.
//
// Ports:
//   Clk, Rst              clock, asynchronous active-low reset
//   PC_Write, IF_Write    hazard-unit enables for the PC and IF/ID
//   bubble                hazard-unit status, not used here
//   addrSel               00 seq, 01 jump, 10 branch, 11 exception vector
//   JumpTarget            jump target from ID
//   BranchTarget          branch target from EX
//   IMemReq, IMemAddr     fetch request and word-aligned address (= PC)
//   IMemAck, IMemData     request accepted / instruction word that cycle
//   InstrID, PCPlus4ID    IF/ID instruction and PC+4
//   ValidID               IF/ID holds a real instruction
//   PCOut                 current PC
//   FetchCnt, SquashCnt   (optional) valid loads / redirect-discarded fetches
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PC_Write,
  input  logic        IF_Write,
  input  logic        bubble,
  input  logic [1:0]  addrSel,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] InstrID,
  output logic [31:0] PCPlus4ID,
  output logic        ValidID,
  output logic [31:0] PCOut
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCnt,
  output logic [31:0] SquashCnt
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_REQ    = 2'd1,
    S_SQUASH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcp4_q, pcp4_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            fetch_inc, discard_inc;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;

  // bubble is informational only
  logic unused_bubble;
  assign unused_bubble = bubble;

  assign redirect = PC_Write && (addrSel != 2'b00);
  assign pc_plus4 = pc_q + XLEN'(4);

  // Redirect target selection, forced word aligned
  always_comb begin
    target = EXC_VECTOR;
    case (addrSel)
      2'b01:   target = JumpTarget;
      2'b10:   target = BranchTarget;
      default: target = EXC_VECTOR;
    endcase
    target[1:0] = 2'b00;
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_d     = redir_q;
    instr_d     = instr_q;
    pcp4_d      = pcp4_q;
    valid_d     = valid_q;
    fetch_inc   = 1'b0;
    discard_inc = 1'b0;

    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect) begin
          instr_d = '0;
          pcp4_d  = '0;
          valid_d = 1'b0;
          if (IMemAck) begin
            pc_d        = target;
            discard_inc = 1'b1;
          end else begin
            redir_d = target;
            state_d = S_SQUASH;
          end
        end else if (IMemAck && PC_Write && IF_Write) begin
          instr_d   = IMemData;
          pcp4_d    = pc_plus4;
          valid_d   = 1'b1;
          pc_d      = pc_plus4;
          fetch_inc = 1'b1;
        end else if (IF_Write) begin
          // Fetch discarded or still pending: PC holds, IF/ID gets a NOP
          instr_d = '0;
          pcp4_d  = '0;
          valid_d = 1'b0;
        end
      end

      S_SQUASH: begin
        // Address stays on the squashed PC until the memory acks it
        if (redirect || IF_Write) begin
          instr_d = '0;
          pcp4_d  = '0;
          valid_d = 1'b0;
        end
        if (redirect) begin
          redir_d = target;
        end
        if (IMemAck) begin
          pc_d        = redirect ? target : redir_q;
          discard_inc = 1'b1;
          state_d     = S_REQ;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase

    req_d = (state_d != S_BOOT);
  end

  // State and pipeline registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      redir_q <= '0;
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign IMemReq   = req_q;
  assign IMemAddr  = pc_q;
  assign PCOut     = pc_q;
  assign InstrID   = instr_q;
  assign PCPlus4ID = pcp4_q;
  assign ValidID   = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q, squash_cnt_q;

  // Wrapping event counters
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (fetch_inc)   fetch_cnt_q  <= fetch_cnt_q + XLEN'(1);
      if (discard_inc) squash_cnt_q <= squash_cnt_q + XLEN'(1);
    end
  end

  assign FetchCnt  = fetch_cnt_q;
  assign SquashCnt = squash_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = fetch_inc ^ discard_inc;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, table-driven bench for fetch_stage.
module tb_fetch_stage;

  logic        Clk;
  logic        Rst;
  logic        PC_Write;
  logic        IF_Write;
  logic        bubble;
  logic [1:0]  addrSel;
  logic [31:0] JumpTarget;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [31:0] InstrID;
  logic [31:0] PCPlus4ID;
  logic        ValidID;
  logic [31:0] PCOut;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCnt;
  logic [31:0] SquashCnt;
`endif

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .PC_Write     (PC_Write),
    .IF_Write     (IF_Write),
    .bubble       (bubble),
    .addrSel      (addrSel),
    .JumpTarget   (JumpTarget),
    .BranchTarget (BranchTarget),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemAck      (IMemAck),
    .IMemData     (IMemData),
    .InstrID      (InstrID),
    .PCPlus4ID    (PCPlus4ID),
    .ValidID      (ValidID),
    .PCOut        (PCOut)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCnt     (FetchCnt),
    .SquashCnt    (SquashCnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instruction memory: word is a fixed function of its address
  function automatic logic [31:0] d(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign IMemData = d(IMemAddr);

  typedef struct {
    logic        pcw;
    logic        ifw;
    logic [1:0]  asel;
    logic [31:0] jt;
    logic [31:0] bt;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pcp4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic pcw, input logic ifw, input logic [1:0] asel,
                              input logic [31:0] jt, input logic [31:0] bt, input logic ack,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_instr, input logic [31:0] e_pcp4);
    vec_t v;
    v.pcw = pcw; v.ifw = ifw; v.asel = asel; v.jt = jt; v.bt = bt; v.ack = ack;
    v.e_req = 1'b1; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pcp4 = e_pcp4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pcw, input logic ifw, input logic [1:0] asel,
                       input logic [31:0] jt, input logic [31:0] bt, input logic ack);
    PC_Write = pcw; IF_Write = ifw; addrSel = asel;
    JumpTarget = jt; BranchTarget = bt; IMemAck = ack;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_instr,
                         input logic [31:0] e_pcp4);
    chk({tag, ".req"},   32'(IMemReq),  32'(e_req));
    chk({tag, ".addr"},  IMemAddr,      e_addr);
    chk({tag, ".valid"}, 32'(ValidID),  32'(e_valid));
    chk({tag, ".instr"}, InstrID,       e_instr);
    chk({tag, ".pcp4"},  PCPlus4ID,     e_pcp4);
  endtask

  initial begin
    // Sequential fetch with zero-wait ack
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h000, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h004, 1, d(32'h000), 32'h004));
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h008, 1, d(32'h004), 32'h008));
    // Load stall at 0x8
    vecs.push_back(mk(0,0,2'b00,0,0,1, 32'h008, 1, d(32'h004), 32'h008));
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h00C, 1, d(32'h008), 32'h00C));
    // Jump with ack, IF_Write=0 still squashes
    vecs.push_back(mk(1,0,2'b01,32'h400,0,1, 32'h400, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h404, 1, d(32'h400), 32'h404));
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h408, 1, d(32'h404), 32'h408));
    // Jump to 0x20, then branch (unaligned target) with ack withheld 3 cycles
    vecs.push_back(mk(1,1,2'b01,32'h020,0,1, 32'h020, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b10,0,32'h123,0, 32'h020, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b00,0,0,0, 32'h020, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b00,0,0,0, 32'h020, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h120, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h124, 1, d(32'h120), 32'h124));
    // Two redirects while squashing: exception vector wins
    vecs.push_back(mk(1,1,2'b01,32'h300,0,0, 32'h124, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b11,0,0,0, 32'h124, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h080, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h084, 1, d(32'h080), 32'h084));
    // addrSel without PC_Write is ignored
    vecs.push_back(mk(0,0,2'b01,32'h999,0,1, 32'h084, 1, d(32'h080), 32'h084));
    // !PC_Write with IF_Write: data discarded, NOP load
    vecs.push_back(mk(0,1,2'b00,0,0,1, 32'h084, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h088, 1, d(32'h084), 32'h088));
    // Redirect in SQUASH on the ack cycle uses the same-cycle target
    vecs.push_back(mk(1,1,2'b01,32'h500,0,0, 32'h088, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b10,0,32'h600,1, 32'h600, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h604, 1, d(32'h600), 32'h604));
    // Pending fetch: IF/ID holds without IF_Write, NOPs with it
    vecs.push_back(mk(1,0,2'b00,0,0,0, 32'h604, 1, d(32'h600), 32'h604));
    vecs.push_back(mk(1,1,2'b00,0,0,0, 32'h604, 0, 0, 0));
    vecs.push_back(mk(1,1,2'b00,0,0,1, 32'h608, 1, d(32'h604), 32'h608));

    bubble = 1'b0;
    Rst = 1'b0;
    drive(1, 1, 2'b00, 0, 0, 1);
    #12;
    chk("reset.req", 32'(IMemReq), 32'd0);
    chk("reset.pc", PCOut, 32'h0);
    chk("reset.valid", 32'(ValidID), 32'd0);
    chk("reset.instr", InstrID, 32'h0);
    chk("reset.pcp4", PCPlus4ID, 32'h0);

    @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("boot.req", 32'(IMemReq), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pcw, vecs[i].ifw, vecs[i].asel, vecs[i].jt, vecs[i].bt, vecs[i].ack);
      bubble = ~bubble;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
              vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pcp4);
    end

    // PC+4 wraps at the top of the address space
    drive(1, 1, 2'b01, 32'hFFFF_FFFF, 0, 1);
    step();
    chk_out("wrap.jump", 1, 32'hFFFF_FFFC, 0, 0, 0);
    drive(1, 1, 2'b00, 0, 0, 1);
    step();
    chk_out("wrap.load", 1, 32'h0000_0000, 1, d(32'hFFFF_FFFC), 32'h0000_0000);

    // Reset asserted mid-SQUASH abandons the request and the pending target
    drive(1, 1, 2'b01, 32'h700, 0, 0);
    step();
    chk_out("sq.enter", 1, 32'h0000_0000, 0, 0, 0);
    drive(1, 1, 2'b00, 0, 0, 0);
    #2;
    Rst = 1'b0;
    #1;
    chk("rst_mid.req", 32'(IMemReq), 32'd0);
    chk("rst_mid.pc", PCOut, 32'h0);
    chk("rst_mid.valid", 32'(ValidID), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    drive(1, 1, 2'b00, 0, 0, 1);
    #1;
    chk("rst_mid.boot", 32'(IMemReq), 32'd0);
    step();
    chk_out("rst_mid.req0", 1, 32'h0, 0, 0, 0);
    step();
    chk_out("rst_mid.fetch", 1, 32'h4, 1, d(32'h0), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
